// File: rtl/seq_lock_pkg.sv
// Purpose: shared types and default constants for the seq_lock combination lock.
// Latency: n/a (package only).
// Backpressure: n/a.
package seq_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    ERR     = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam int TRIES_W = 4;
  localparam logic [TRIES_W-1:0] TRIES_SAT = '1;

  localparam int          LEN_DEF         = 5;
  localparam logic [15:0] KEY_DEF         = 16'b10110;
  localparam int          MAX_TRIES_DEF   = 3;
  localparam int          LOCK_CYCLES_DEF = 100;

endpackage

// File: rtl/lock_timer.sv
// Purpose: loadable down-counter that times the lockout window.
// Latency: value visible the cycle after load; done is combinational on the count.
// Backpressure: none; counts down every cycle until it reaches zero and holds there.
//
// Ports: CLK, RESET (sync, active-high), load/value (start a new window),
//        done (count has reached zero).
module lock_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/seq_lock.sv
// Purpose: serial-entry combination lock; one key bit per STB, green on match, red on miss.
// Latency: R/G/LOCKED/CNT/TRIES update on the edge that samples STB/CLR (visible next cycle).
// Backpressure: none; STB and CLR are ignored while the lockout window is active.
//
// Ports: CLK, RESET (sync, active-high), STB (key bit strobe), S (key bit),
//        CLR (abandon entry / relock), R/G (red/green), CNT (bits entered),
//        TRIES (consecutive failures), LOCKED (lockout active).
// Build option: define SEQ_LOCK_LOCKOUT_EN to compile the timed lockout after
//   MAX_TRIES consecutive failures; otherwise LOCKED is tied low and TRIES saturates.
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter int             LEN         = LEN_DEF,
  parameter logic [LEN-1:0] KEY         = LEN'(KEY_DEF),
  parameter int             MAX_TRIES   = MAX_TRIES_DEF,
  parameter int             LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       STB,
  input  logic                       S,
  input  logic                       CLR,
  output logic                       R,
  output logic                       G,
  output logic [$clog2(LEN+1)-1:0]   CNT,
  output logic [TRIES_W-1:0]         TRIES,
  output logic                       LOCKED
);

  localparam int CW = $clog2(LEN+1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt_nxt;
  logic [LEN-2:0]     shift, shift_nxt;
  logic [TRIES_W-1:0] tries_nxt;
  logic [LEN-1:0]     word;

`ifdef SEQ_LOCK_LOCKOUT_EN
  localparam int TMR_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic tmr_load;
  logic tmr_done;

  lock_timer #(.W(TMR_W)) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (tmr_load),
    .value (TMR_W'(LOCK_CYCLES - 1)),
    .done  (tmr_done)
  );
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = CNT;
    shift_nxt = shift;
    tries_nxt = TRIES;
    // Full pattern as it would stand with the current bit appended last.
    word      = {shift, S};
`ifdef SEQ_LOCK_LOCKOUT_EN
    tmr_load  = 1'b0;
`endif
    case (state)
      ENTRY: begin
        if (CLR) begin
          cnt_nxt   = '0;
          shift_nxt = '0;
        end else if (STB) begin
          if (CNT == CW'(LEN - 1)) begin
            cnt_nxt   = '0;
            shift_nxt = '0;
            if (word == KEY) begin
              state_nxt = OPEN;
              tries_nxt = '0;
            end
`ifdef SEQ_LOCK_LOCKOUT_EN
            else if (int'(TRIES) + 1 >= MAX_TRIES) begin
              state_nxt = LOCKOUT;
              tries_nxt = TRIES_W'(MAX_TRIES);
              tmr_load  = 1'b1;
            end
`endif
            else begin
              state_nxt = ERR;
              tries_nxt = (TRIES == TRIES_SAT) ? TRIES : TRIES + 1'b1;
            end
          end else begin
            cnt_nxt   = CNT + 1'b1;
            shift_nxt = word[LEN-2:0];
          end
        end
      end
      OPEN: begin
        // A strobe here only relocks; its bit is not part of a new attempt.
        if (CLR || STB) state_nxt = ENTRY;
      end
      ERR: begin
        if (CLR) begin
          state_nxt = ENTRY;
        end else if (STB) begin
          // The strobe that leaves ERR is already bit 1 of the next attempt.
          state_nxt = ENTRY;
          cnt_nxt   = CW'(1);
          shift_nxt = (LEN-1)'(S);
        end
      end
`ifdef SEQ_LOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (tmr_done) begin
          state_nxt = ENTRY;
          tries_nxt = '0;
        end
      end
`endif
      default: state_nxt = ENTRY;
    endcase
  end

  // Indicators are registered decodes of the next state, so they change on
  // the same edge as the state itself.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ENTRY;
      CNT   <= '0;
      shift <= '0;
      TRIES <= '0;
      R     <= 1'b0;
      G     <= 1'b0;
`ifdef SEQ_LOCK_LOCKOUT_EN
      LOCKED <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      CNT   <= cnt_nxt;
      shift <= shift_nxt;
      TRIES <= tries_nxt;
      R     <= (state_nxt == ERR) || (state_nxt == LOCKOUT);
      G     <= (state_nxt == OPEN);
`ifdef SEQ_LOCK_LOCKOUT_EN
      LOCKED <= (state_nxt == LOCKOUT);
`endif
    end
  end

`ifndef SEQ_LOCK_LOCKOUT_EN
  assign LOCKED = 1'b0;
`endif

endmodule

// File: tb/tb_seq_lock.sv
module tb_seq_lock;

  localparam int         LEN         = 5;
  localparam logic [4:0] KEY         = 5'b10110;
  localparam int         MAX_TRIES   = 3;
  localparam int         LOCK_CYCLES = 8;
`ifdef SEQ_LOCK_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       STB = 1'b0;
  logic       S = 1'b0;
  logic       CLR = 1'b0;
  logic       R, G, LOCKED;
  logic [2:0] CNT;
  logic [3:0] TRIES;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the entered bits as a list, plus what the lock is showing.
  int bq[$];
  int m_tries = 0;
  bit m_green = 1'b0;
  bit m_err   = 1'b0;
  int m_lock  = 0;   // remaining lockout cycles, 0 when not locked out

  seq_lock #(
    .LEN(LEN), .KEY(KEY), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .CLK(CLK), .RESET(RESET), .STB(STB), .S(S), .CLR(CLR),
    .R(R), .G(G), .CNT(CNT), .TRIES(TRIES), .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit rst, input bit stb, input bit s, input bit clr);
    int v;
    if (rst) begin
      bq.delete(); m_tries = 0; m_green = 0; m_err = 0; m_lock = 0;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_tries = 0;
    end else if (m_green) begin
      if (clr || stb) m_green = 0;
    end else if (m_err) begin
      if (clr) m_err = 0;
      else if (stb) begin
        m_err = 0; bq.delete(); bq.push_back(int'(s));
      end
    end else if (clr) begin
      bq.delete();
    end else if (stb) begin
      bq.push_back(int'(s));
      if (bq.size() == LEN) begin
        v = 0;
        foreach (bq[i]) v = v * 2 + bq[i];
        bq.delete();
        if (v == int'(KEY)) begin
          m_green = 1; m_tries = 0;
        end else if (LOCK_EN && m_tries + 1 == MAX_TRIES) begin
          m_lock = LOCK_CYCLES; m_tries = MAX_TRIES;
        end else begin
          m_err = 1;
          if (m_tries < 15) m_tries++;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit stb, input bit s, input bit clr);
    RESET = rst; STB = stb; S = s; CLR = clr;
    @(posedge CLK);
    model(rst, stb, s, clr);
    #1;
    chk("G", 32'(G), 32'(m_green));
    chk("R", 32'(R), 32'(m_err || m_lock > 0));
    chk("LOCKED", 32'(LOCKED), 32'(m_lock > 0));
    chk("CNT", 32'(CNT), 32'(bq.size()));
    chk("TRIES", 32'(TRIES), 32'(m_tries));
  endtask

  task automatic enter(input logic [4:0] pat);
    for (int i = 4; i >= 0; i--) step(1'b0, 1'b1, pat[i], 1'b0);
  endtask

  function automatic logic [4:0] wrong_pat();
    logic [4:0] p;
    do p = 5'($urandom_range(0, 31)); while (p == KEY);
    return p;
  endfunction

  initial begin
    // Reset state.
    step(1, 0, 0, 0);
    step(1, 1, 1, 1);
    step(0, 0, 0, 0);

    // Correct key opens, CLR relocks.
    enter(5'b10110);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Wrong key shows red; next strobe is bit 1 of a new attempt.
    enter(5'b11111);
    step(0, 1, 1, 0);
    step(0, 0, 0, 1);

    // Three consecutive failures: lockout window with strobes/clears ignored.
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      enter(wrong_pat());
      if (k < 2) step(0, 0, 0, 1);
    end
    for (int i = 0; i < LOCK_CYCLES + 3; i++)
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(0, 0, 0, 1);

    // Simultaneous STB and CLR mid-entry: clear wins.
    step(1, 0, 0, 0);
    step(0, 1, 1, 0); step(0, 1, 0, 0); step(0, 1, 1, 0);
    step(0, 1, 1, 1);
    enter(KEY);
    step(0, 1, 0, 1);

    // Success clears the failure count.
    step(1, 0, 0, 0);
    enter(wrong_pat()); step(0, 0, 0, 1);
    enter(wrong_pat()); step(0, 0, 0, 1);
    enter(KEY);         step(0, 0, 0, 1);
    enter(wrong_pat()); step(0, 0, 0, 1);

    // Reset in the middle of a lockout window.
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      enter(wrong_pat());
      if (k < 2) step(0, 0, 0, 1);
    end
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Long run of failures: saturation (or repeated lockouts).
    step(1, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      enter(wrong_pat());
      repeat (LOCK_CYCLES + 1) step(0, 0, 0, 1);
    end
    enter(wrong_pat());
    step(0, 0, 0, 1);

    // Randomized mix of attempts and raw strobes.
    step(1, 0, 0, 0);
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0: enter(KEY);
        1: enter(5'($urandom_range(0, 31)));
        default:
          for (int i = 0; i < 8; i++)
            step($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_lock.md
# seq_lock

Parametrised serial-entry combination lock for the lab-board top level: the next generation of the two-light red/green sequence FSM. It samples one key bit per strobe from a debounced pushbutton, compares a programmable LEN-bit pattern, and drives green on success and red on failure. It also counts failed attempts and enforces a timed lockout. It sits between the push-button synchroniser and the LED/indicator outputs.

## Interface
- LEN, 5, pattern length in bits (2..16)
- KEY, 5'b10110, expected pattern, LEN bits, first-entered bit is MSB
- MAX_TRIES, 3, consecutive failures that trigger lockout (1..15)
- LOCK_CYCLES, 100, lockout duration in CLK cycles (1 s at hz100)

- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- STB  in  1  one-cycle pulse: key bit valid on S
- S  in  1  key bit value, sampled only when STB=1
- CLR  in  1  abandon current entry / relock
- R  out  1  red indicator
- G  out  1  green indicator
- CNT  out  $clog2(LEN+1)  bits entered so far in current attempt
- TRIES  out  4  consecutive failed attempts
- LOCKED  out  1  lockout active

## Operation
- States (Moore): ENTRY, OPEN, ERR, LOCKOUT. Outputs decode from registered state.
- ENTRY: R=0, G=0. On STB, shift S into SHIFT (MSB first) and increment CNT. On the STB that makes CNT reach LEN, compare {SHIFT,S} to KEY:
  - match -> OPEN, TRIES<=0
  - mismatch, TRIES+1 < MAX_TRIES -> ERR, TRIES<=TRIES+1
  - mismatch, TRIES+1 == MAX_TRIES -> LOCKOUT, TRIES<=MAX_TRIES, timer<=LOCK_CYCLES-1
  - In all three cases CNT<=0 and SHIFT<=0.
- CLR in ENTRY: CNT<=0 and SHIFT<=0. Stay in ENTRY; TRIES is unchanged.
- OPEN: G=1. CLR or STB -> ENTRY. The STB bit is discarded.
- ERR: R=1. On STB -> ENTRY, and that bit is taken as bit 1 of the new attempt (CNT<=1). CLR -> ENTRY with CNT=0.
- LOCKOUT: R=1, LOCKED=1. STB and CLR are ignored. Timer decrements each cycle. At timer==0 -> ENTRY and TRIES<=0.
- Simultaneous STB and CLR: CLR wins in every state except LOCKOUT, where both are ignored.
- A successful attempt resets TRIES; failures only accumulate consecutively.

## Timing
- Reset values: state ENTRY, R=0, G=0, CNT=0, TRIES=0, LOCKED=0, SHIFT=0, timer=0.
- Latency: R/G/LOCKED/CNT/TRIES update on the CLK edge that samples the STB/CLR, and are visible one cycle after the strobe.
- LOCKOUT lasts exactly LOCK_CYCLES cycles: LOCKED is high for LOCK_CYCLES cycles, then ENTRY.
- RESET mid-lockout or mid-entry returns to the reset state on the next edge; no partial state survives.
- STB is assumed to be a single-cycle pulse. A held STB is sampled every cycle it is high.

## Configuration
- SEQ_LOCK_LOCKOUT_EN defined: behaviour as above.
- SEQ_LOCK_LOCKOUT_EN undefined:
  - LOCKOUT state, timer and LOCKED logic are not compiled. LOCKED is tied to 0.
  - Every mismatch goes to ERR.
  - TRIES saturates at 15 and is cleared only by a match or RESET.

## Structure
- Package seq_lock_pkg: typedef enum state_t {ENTRY, OPEN, ERR, LOCKOUT}, TRIES width constant (4), default parameter constants.
- Sub-module lock_timer: loadable down-counter (load, value, done), instantiated only under SEQ_LOCK_LOCKOUT_EN.

## Test plan
All scenarios use LEN=5, KEY=5'b10110, MAX_TRIES=3, LOCK_CYCLES=8.
- Enter bits 1,0,1,1,0 -> G=1 the cycle after the 5th STB, TRIES=0, CNT=0. Then CLR -> G=0 and state ENTRY.
- Enter 1,1,1,1,1 -> R=1, TRIES=1. Next STB with S=1 -> R=0, CNT=1.
- Three wrong patterns in a row -> LOCKED=1 and R=1 for exactly 8 cycles. STB and CLR during this window have no effect. Afterwards TRIES=0 and R=0.
- Enter 1,0,1, then STB+CLR together -> CNT=0. Then the full key -> G=1.
- Two failures, then the correct key -> G=1, TRIES=0. A following wrong pattern gives TRIES=1, not lockout.
- Assert RESET during lockout (cycle 3) -> next cycle LOCKED=0, R=0, TRIES=0, CNT=0.
- With SEQ_LOCK_LOCKOUT_EN undefined, 16 wrong patterns -> TRIES saturates at 15 and LOCKED stays 0 throughout.
